// File: rtl/rom_dl_packer.sv
// Packs the data_io byte download into 16-bit big-endian SDRAM words through a small word FIFO.
// Words leave the FIFO one cycle after push at the earliest; wr_ack pops, and a push into a full FIFO without a pop is dropped and flagged.
module rom_dl_packer #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  PAD_BYTE   = 8'hFF
) (
    input  logic        clk_72,
    input  logic        reset,
    input  logic        ioctl_downl,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [3:0]  pcb,
    output logic        tate,
    output logic [7:0]  brd,
    output logic        wr_req,
    output logic [23:0] wr_addr,
    output logic [15:0] wr_data,
    input  logic        wr_ack,
    output logic        rom_loaded,
    output logic        overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
    } word_t;

    state_t       state;
    logic         downl_q;
    logic         rise;
    logic         fall;

    logic [7:0]   held;
    logic [23:0]  held_addr;
    logic         held_vld;

    word_t        mem [FIFO_DEPTH];
    word_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]  count;

    logic [24:0]  offset;
    logic         byte_ok;
    logic         hdr0;
    logic         hdr1;
    logic         pay_even;
    logic         pay_odd;
    logic         flush;
    logic         push;
    word_t        push_word;
    logic         full;
    logic         pop;
    logic         do_push;

    assign rise = ioctl_downl && !downl_q;
    assign fall = !ioctl_downl && downl_q;

    // A strobe coinciding with a download restart is discarded along with everything else.
    assign offset   = ioctl_addr - 25'd2;
    assign byte_ok  = ioctl_wr && (state == LOAD) && !rise;
    assign hdr0     = byte_ok && (ioctl_addr == 25'd0);
    assign hdr1     = byte_ok && (ioctl_addr == 25'd1);
    assign pay_even = byte_ok && (ioctl_addr >= 25'd2) && !offset[0];
    assign pay_odd  = byte_ok && (ioctl_addr >= 25'd2) && offset[0];
    assign flush    = (state == DRAIN) && held_vld;

    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (pay_odd) begin
            push      = 1'b1;
            push_word = '{addr: offset[24:1],
                          data: {(held_vld ? held : PAD_BYTE), ioctl_dout}};
        end else if ((pay_even && held_vld) || flush) begin
            push      = 1'b1;
            push_word = '{addr: held_addr, data: {held, PAD_BYTE}};
        end
    end

    assign full    = (count == DEPTH_C);
    assign wr_req  = (count != '0);
    assign pop     = wr_ack && wr_req;
    assign do_push = push && !rise && (!full || pop);

    assign head    = mem[rd_ptr];
    assign wr_addr = wr_req ? head.addr : '0;
    assign wr_data = wr_req ? head.data : '0;

    always_ff @(posedge clk_72) begin
        if (reset) begin
            downl_q <= 1'b0;
        end else begin
            downl_q <= ioctl_downl;
        end
    end

    always_ff @(posedge clk_72) begin
        if (reset) begin
            state      <= IDLE;
            rom_loaded <= 1'b0;
        end else if (rise) begin
            state      <= LOAD;
            rom_loaded <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (fall) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // A pending flush always pushes first, so an empty FIFO here means truly drained.
                    if (!held_vld && (count == '0)) begin
                        state      <= DONE;
                        rom_loaded <= 1'b1;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    always_ff @(posedge clk_72) begin
        if (reset) begin
            pcb  <= '0;
            tate <= 1'b0;
            brd  <= '0;
        end else if (hdr0) begin
            pcb  <= ioctl_dout[3:0];
            tate <= ioctl_dout[7];
        end else if (hdr1) begin
            brd  <= ioctl_dout;
        end
    end

    always_ff @(posedge clk_72) begin
        if (reset || rise) begin
            held      <= '0;
            held_addr <= '0;
            held_vld  <= 1'b0;
        end else if (pay_even) begin
            held      <= ioctl_dout;
            held_addr <= offset[24:1];
            held_vld  <= 1'b1;
        end else if (pay_odd || flush) begin
            held_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk_72) begin
        if (do_push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk_72) begin
        if (reset || rise) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_dl_packer.sv
// Scoreboard bench for rom_dl_packer: expected SDRAM words are queued as bytes are driven and checked at each ack.
module tb_rom_dl_packer;

    logic        clk_72 = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_downl = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [3:0]  pcb;
    logic        tate;
    logic [7:0]  brd;
    logic        wr_req;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack = 1'b0;
    logic        rom_loaded;
    logic        overflow;

    int total = 0;
    int bad = 0;
    int n_wr = 0;
    logic ack_en = 1'b0;
    int ack_delay = 1;
    logic [39:0] sb [$];

    rom_dl_packer #(.FIFO_DEPTH(4), .PAD_BYTE(8'hFF)) dut (
        .clk_72(clk_72), .reset(reset), .ioctl_downl(ioctl_downl),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .pcb(pcb), .tate(tate), .brd(brd), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack), .rom_loaded(rom_loaded), .overflow(overflow)
    );

    always #5 clk_72 = ~clk_72;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_72);
        #1;
    endtask

    task automatic wr_byte(input int addr, input logic [7:0] dat);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(addr);
        ioctl_dout = dat;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl();
        ioctl_downl = 1'b1;
        tick();
        tick();
    endtask

    task automatic end_dl();
        ioctl_downl = 1'b0;
        tick();
    endtask

    task automatic wait_loaded(input string tag);
        int n = 0;
        @(negedge clk_72);
        while (!rom_loaded && n < 300) begin
            @(negedge clk_72);
            n++;
        end
        check(tag, 64'(rom_loaded), 64'd1);
        tick();
    endtask

    task automatic observe(input int cycles);
        repeat (cycles) @(negedge clk_72);
        tick();
    endtask

    // Ack responder: checks the FIFO head against the scoreboard on every write it accepts.
    initial begin
        logic [39:0] cap;
        logic [39:0] exp;
        forever begin
            @(negedge clk_72);
            if (wr_req && ack_en) begin
                cap = {wr_addr, wr_data};
                if (ack_delay > 0) begin
                    repeat (ack_delay) @(negedge clk_72);
                    check("head_stable", 64'({wr_addr, wr_data}), 64'(cap));
                end
                check("write_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    check("write_word", 64'({wr_addr, wr_data}), 64'(exp));
                end
                n_wr++;
                wr_ack = 1'b1;
                @(posedge clk_72);
                #1;
                wr_ack = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        repeat (3) tick();
        @(negedge clk_72);
        check("rst_wr_req", 64'(wr_req), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_loaded", 64'(rom_loaded), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_pcb", 64'(pcb), 64'd0);
        check("rst_brd", 64'(brd), 64'd0);
        check("rst_tate", 64'(tate), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // header decode, then a single word with a slow ack
        ack_en = 1'b1;
        ack_delay = 3;
        start_dl();
        wr_byte(0, 8'h83);
        wr_byte(1, 8'h05);
        observe(3);
        check("hdr_tate", 64'(tate), 64'd1);
        check("hdr_pcb", 64'(pcb), 64'd3);
        check("hdr_brd", 64'(brd), 64'h05);
        check("hdr_no_req", 64'(wr_req), 64'd0);
        w0 = n_wr;
        wr_byte(2, 8'h12);
        sb.push_back({24'd0, 16'h1234});
        ioctl_wr = 1'b1; ioctl_addr = 25'd3; ioctl_dout = 8'h34;
        @(negedge clk_72);
        check("push_latency", 64'(wr_req), 64'd0);
        tick();
        ioctl_wr = 1'b0;
        observe(6);
        check("loaded_during_load", 64'(rom_loaded), 64'd0);
        end_dl();
        wait_loaded("loaded_single");
        check("count_single", 64'(n_wr - w0), 64'd1);

        // odd-length payload with trailing pad; header retained across restart
        ack_delay = 1;
        start_dl();
        @(negedge clk_72);
        check("restart_clears_loaded", 64'(rom_loaded), 64'd0);
        check("hdr_retained", 64'(pcb), 64'd3);
        tick();
        w0 = n_wr;
        sb.push_back({24'd0, 16'hAABB});
        sb.push_back({24'd1, 16'hCCDD});
        sb.push_back({24'd2, 16'hEEFF});
        wr_byte(2, 8'hAA); wr_byte(3, 8'hBB); wr_byte(4, 8'hCC);
        wr_byte(5, 8'hDD); wr_byte(6, 8'hEE);
        end_dl();
        wait_loaded("loaded_odd_len");
        check("count_odd_len", 64'(n_wr - w0), 64'd3);

        // held byte displaced by a new even byte, and odd bytes with nothing held
        start_dl();
        w0 = n_wr;
        sb.push_back({24'd0, 16'h66FF});
        sb.push_back({24'd1, 16'h7788});
        sb.push_back({24'd3, 16'hFF99});
        wr_byte(2, 8'h66); wr_byte(4, 8'h77); wr_byte(5, 8'h88); wr_byte(9, 8'h99);
        end_dl();
        wait_loaded("loaded_skip");
        check("count_skip", 64'(n_wr - w0), 64'd3);

        // stalled acks: only four words fit, the rest are dropped
        ack_en = 1'b0;
        start_dl();
        w0 = n_wr;
        for (int k = 0; k < 4; k++) sb.push_back({24'(k), 8'(2 + 2 * k), 8'(3 + 2 * k)});
        for (int a = 2; a < 14; a++) wr_byte(a, 8'(a));
        observe(1);
        check("ovf_set", 64'(overflow), 64'd1);
        check("ovf_req", 64'(wr_req), 64'd1);
        check("ovf_head", 64'({wr_addr, wr_data}), 64'({24'd0, 16'h0203}));
        end_dl();
        observe(5);
        check("ovf_not_loaded", 64'(rom_loaded), 64'd0);
        ack_en = 1'b1;
        wait_loaded("loaded_ovf");
        check("count_ovf", 64'(n_wr - w0), 64'd4);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // full FIFO with push and pop in the same cycle
        ack_en = 1'b0;
        start_dl();
        @(negedge clk_72);
        check("ovf_cleared", 64'(overflow), 64'd0);
        tick();
        w0 = n_wr;
        for (int k = 0; k < 5; k++) sb.push_back({24'(k), 8'(16 + 2 * k), 8'(17 + 2 * k)});
        for (int a = 2; a < 11; a++) wr_byte(a, 8'(a + 14));
        ack_delay = 0;
        ioctl_wr = 1'b1; ioctl_addr = 25'd11; ioctl_dout = 8'd25;
        ack_en = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        ack_en = 1'b0;
        @(negedge clk_72);
        check("full_pushpop_no_ovf", 64'(overflow), 64'd0);
        tick();
        ack_delay = 1;
        ack_en = 1'b1;
        end_dl();
        wait_loaded("loaded_full");
        check("count_full", 64'(n_wr - w0), 64'd5);

        // reset with queued words abandons them
        ack_en = 1'b0;
        start_dl();
        for (int a = 2; a < 6; a++) wr_byte(a, 8'(a + 48));
        observe(1);
        check("pre_reset_req", 64'(wr_req), 64'd1);
        reset = 1'b1;
        ioctl_downl = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk_72);
        check("post_reset_req", 64'(wr_req), 64'd0);
        check("post_reset_pcb", 64'(pcb), 64'd0);
        tick();
        w0 = n_wr;
        start_dl();
        sb.push_back({24'd0, 16'hA1B2});
        wr_byte(2, 8'hA1);
        wr_byte(3, 8'hB2);
        ack_en = 1'b1;
        end_dl();
        wait_loaded("loaded_after_reset");
        check("count_after_reset", 64'(n_wr - w0), 64'd1);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
